// File: rtl/tl_rom_slave.sv
// Read-only TileLink-UL slave: single-beat Gets served from a synchronous ROM macro,
// with a one-entry address/ROM pipeline stage feeding an in-order response queue.
module tl_rom_slave #(
  parameter int unsigned SRC_W      = 10,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned ROM_WORDS  = 4096,
  parameter int unsigned RESP_DEPTH = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         auto_in_a_ready,
  input  logic                         auto_in_a_valid,
  input  logic [2:0]                   auto_in_a_bits_opcode,
  input  logic [2:0]                   auto_in_a_bits_param,
  input  logic [1:0]                   auto_in_a_bits_size,
  input  logic [SRC_W-1:0]             auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]            auto_in_a_bits_address,
  input  logic [7:0]                   auto_in_a_bits_mask,
  input  logic                         auto_in_a_bits_corrupt,
  input  logic                         auto_in_d_ready,
  output logic                         auto_in_d_valid,
  output logic [1:0]                   auto_in_d_bits_size,
  output logic [SRC_W-1:0]             auto_in_d_bits_source,
  output logic [63:0]                  auto_in_d_bits_data,
  output logic                         rom_req,
  output logic [$clog2(ROM_WORDS)-1:0] rom_addr,
  input  logic [63:0]                  rom_rdata,
  output logic                         status_illegal
);

  localparam int unsigned ROM_AW = $clog2(ROM_WORDS);
  localparam int unsigned IDX_W  = ADDR_W - 3;
  localparam int unsigned PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam logic [2:0]  OP_GET = 3'd4;

  typedef struct packed {
    logic [1:0]       size;
    logic [SRC_W-1:0] source;
    logic [63:0]      data;
  } resp_t;

  logic             a_ready_q;
  logic             a_ready_nxt;
  logic             a_fire;
  logic             a_illegal;
  logic             a_zero;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;

  logic             p_valid_q;
  logic [1:0]       p_size_q;
  logic [SRC_W-1:0] p_source_q;
  logic [7:0]       p_mask_q;
  logic             p_zero_q;
  logic [63:0]      p_data;

  resp_t            q_mem [RESP_DEPTH];
  resp_t            q_head;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             enq;
  logic             deq;
  logic             d_valid;
  logic             status_q;
  logic             unused_a;

  // Only the mask selects lanes; param and the sub-word address bits carry no meaning here.
  assign unused_a = ^{auto_in_a_bits_param, auto_in_a_bits_address[2:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == RESP_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Request decode: out-of-range and illegal requests are answered with zero data.
  assign word_idx  = auto_in_a_bits_address[ADDR_W-1:3];
  assign in_range  = 32'(word_idx) < ROM_WORDS;
  assign a_illegal = (auto_in_a_bits_opcode != OP_GET) | auto_in_a_bits_corrupt;
  assign a_zero    = !in_range | a_illegal;
  assign a_fire    = auto_in_a_valid & a_ready_q;
  assign rom_req   = a_fire & !a_zero;
  assign rom_addr  = auto_in_a_bits_address[ROM_AW+2:3];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_valid_q  <= 1'b0;
      p_size_q   <= '0;
      p_source_q <= '0;
      p_mask_q   <= '0;
      p_zero_q   <= 1'b0;
    end else begin
      p_valid_q <= a_fire;
      if (a_fire) begin
        p_size_q   <= auto_in_a_bits_size;
        p_source_q <= auto_in_a_bits_source;
        p_mask_q   <= auto_in_a_bits_mask;
        p_zero_q   <= a_zero;
      end
    end
  end

  // Lane masking of the ROM word arriving one cycle after the request.
  always_comb begin
    p_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (p_mask_q[i] && !p_zero_q) begin
        p_data[8*i +: 8] = rom_rdata[8*i +: 8];
      end
    end
  end

  assign d_valid = (count_q != '0);
  assign enq     = p_valid_q;
  assign deq     = d_valid & auto_in_d_ready;
  assign q_head  = q_mem[rd_ptr_q];

  // Occupancy one cycle ahead, so a_ready comes straight from a flop.
  always_comb begin
    count_nxt = count_q;
    if (enq && !deq) begin
      count_nxt = count_q + CNT_W'(1);
    end else if (deq && !enq) begin
      count_nxt = count_q - CNT_W'(1);
    end
    a_ready_nxt = (32'(a_fire) + 32'(count_nxt)) < RESP_DEPTH;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      a_ready_q <= 1'b0;
      status_q  <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (deq) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q   <= count_nxt;
      a_ready_q <= a_ready_nxt;
      if (a_fire && a_illegal) begin
        status_q <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: the head is only visible while count is nonzero.
  always_ff @(posedge clock) begin
    if (enq) begin
      q_mem[wr_ptr_q] <= '{size: p_size_q, source: p_source_q, data: p_data};
    end
  end

  assign auto_in_a_ready       = a_ready_q;
  assign auto_in_d_valid       = d_valid;
  assign auto_in_d_bits_size   = d_valid ? q_head.size   : '0;
  assign auto_in_d_bits_source = d_valid ? q_head.source : '0;
  assign auto_in_d_bits_data   = d_valid ? q_head.data   : '0;
  assign status_illegal        = status_q;

endmodule

// File: tb/tb_tl_rom_slave.sv
// Bench for tl_rom_slave: directed scenarios plus randomized traffic against a
// transaction-level model (ordered response queue and outstanding-request count).
module tb_tl_rom_slave;

  localparam int unsigned SRC_W     = 10;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned ROM_WORDS = 4096;
  localparam int          DEPTH     = 3;

  typedef struct packed {
    logic [2:0]        opcode;
    logic              corrupt;
    logic [1:0]        size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [7:0]        mask;
  } req_t;

  typedef struct packed {
    logic [1:0]       size;
    logic [SRC_W-1:0] source;
    logic [63:0]      data;
  } resp_t;

  logic              clock;
  logic              reset;
  logic              a_ready;
  logic              a_valid;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [1:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [7:0]        a_mask;
  logic              a_corrupt;
  logic              d_ready;
  logic              d_valid;
  logic [1:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic [63:0]       d_data;
  logic              rom_req;
  logic [11:0]       rom_addr;
  logic [63:0]       rom_rdata;
  logic              status_illegal;

  logic [63:0] rom_mem [ROM_WORDS];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    outstanding = 0;
  resp_t exp_q[$];
  resp_t obs_q[$];
  int    acc_cyc_q[$];
  int    obs_cyc_q[$];

  logic        s_ready, s_rom_req, s_dv, s_fired, exp_ready, exp_rom_req;
  logic [11:0] s_rom_addr;
  resp_t       s_d;
  req_t        idle_r;

  tl_rom_slave dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_param   (a_param),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_corrupt (a_corrupt),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_data    (d_data),
    .rom_req                (rom_req),
    .rom_addr               (rom_addr),
    .rom_rdata              (rom_rdata),
    .status_illegal         (status_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM macro: data for the requested word one cycle later, garbage otherwise.
  always @(posedge clock) rom_rdata <= rom_req ? rom_mem[rom_addr] : {$urandom, $urandom};

  function automatic logic is_zero(input req_t r);
    return ((r.address >> 3) >= ROM_WORDS) || (r.opcode != 3'd4) || r.corrupt;
  endfunction

  function automatic resp_t model(input req_t r);
    resp_t       e;
    logic [63:0] w;
    e.size   = r.size;
    e.source = r.source;
    e.data   = '0;
    if (!is_zero(r)) begin
      w = rom_mem[r.address[14:3]];
      for (int i = 0; i < 8; i++) if (r.mask[i]) e.data[8*i +: 8] = w[8*i +: 8];
    end
    return e;
  endfunction

  function automatic req_t mk_get(input logic [16:0] addr, input logic [9:0] src,
                                  input logic [7:0] mask, input logic [1:0] size);
    req_t r;
    r.opcode = 3'd4; r.corrupt = 1'b0; r.size = size;
    r.source = src; r.address = addr; r.mask = mask;
    return r;
  endfunction

  function automatic req_t rand_req(input logic allow_bad);
    req_t r;
    r = mk_get(17'($urandom), 10'($urandom), 8'($urandom), 2'($urandom));
    if (allow_bad && ($urandom % 6 == 0)) r.opcode = 3'($urandom);
    if (allow_bad && ($urandom % 8 == 0)) r.corrupt = 1'b1;
    return r;
  endfunction

  // One clock of stimulus; samples outputs and updates the model's queues.
  task automatic cycle(input logic av, input req_t r, input logic dr);
    @(negedge clock);
    a_valid = av; a_opcode = r.opcode; a_param = 3'($urandom); a_size = r.size;
    a_source = r.source; a_address = r.address; a_mask = r.mask; a_corrupt = r.corrupt;
    d_ready = dr;
    #1;
    s_ready = a_ready; s_rom_req = rom_req; s_rom_addr = rom_addr; s_dv = d_valid;
    s_d = {d_size, d_source, d_data};
    exp_ready   = outstanding < DEPTH;
    exp_rom_req = av && exp_ready && !is_zero(r);
    s_fired = av && a_ready;
    if (s_fired) begin
      exp_q.push_back(model(r)); acc_cyc_q.push_back(cyc); outstanding++;
    end
    if (d_valid && dr) begin
      obs_q.push_back(s_d); obs_cyc_q.push_back(cyc); outstanding--;
    end
    cyc++;
  endtask

  task automatic clear_q();
    exp_q.delete(); obs_q.delete(); acc_cyc_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; a_valid = 1'b1; d_ready = 1'b1;
    a_opcode = 3'd4; a_param = 3'd0; a_size = 2'd3; a_source = 10'h1;
    a_address = 17'h8; a_mask = 8'hFF; a_corrupt = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (a_ready !== 1'b0 || d_valid !== 1'b0 || rom_req !== 1'b0 || status_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl ready=%b dv=%b rom_req=%b status=%b required 0 0 0 0",
               a_ready, d_valid, rom_req, status_illegal);
    end
    checks++;
    if (d_size !== 2'd0 || d_source !== 10'd0 || d_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_dbits size=%0d src=%h data=%h required 0", d_size, d_source, d_data);
    end
    @(negedge clock);
    a_valid = 1'b0; reset = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready got %b required 0", a_ready);
    end
    outstanding = 0; clear_q();
    cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_rise got %b required 1", s_ready);
    end
  endtask

  task automatic test_single_get(input logic [7:0] mask, input logic [63:0] exp_data);
    req_t  r;
    resp_t e;
    clear_q();
    r = mk_get(17'h00010, 10'h155, mask, 2'd3);
    e = '{size: 2'd3, source: 10'h155, data: exp_data};
    cycle(1'b1, r, 1'b1);
    checks++;
    if (s_ready !== 1'b1 || s_rom_req !== 1'b1 || s_rom_addr !== 12'd2) begin
      errors++;
      $display("FAIL single_req ready=%b rom_req=%b rom_addr=%0d required 1 1 2",
               s_ready, s_rom_req, s_rom_addr);
    end
    cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (s_dv !== 1'b0) begin
      errors++; $display("FAIL single_lat_t1 dv=%b required 0", s_dv);
    end
    cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (s_dv !== 1'b1 || s_d !== e) begin
      errors++;
      $display("FAIL single_resp mask=%h dv=%b data=%h src=%h size=%0d required 1 %h %h %0d",
               mask, s_dv, s_d.data, s_d.source, s_d.size, e.data, e.source, e.size);
    end
    cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (s_dv !== 1'b0) begin
      errors++; $display("FAIL single_after dv=%b required 0", s_dv);
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, mk_get(17'(i * 8), 10'(i), 8'hFF, 2'd3), 1'b1);
      checks++;
      if (s_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready req=%0d got %b required 1", i, s_ready);
      end
    end
    for (int k = 0; k < 20 && obs_q.size() < 8; k++) cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (obs_q.size() != 8 || acc_cyc_q.size() != 8) begin
      errors++;
      $display("FAIL b2b_count beats=%0d accepts=%0d required 8 8", obs_q.size(), acc_cyc_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k] || obs_cyc_q[k] != acc_cyc_q[k] + 2) begin
          errors++;
          $display("FAIL b2b_beat %0d src=%h data=%h cyc=%0d required src=%h data=%h cyc=%0d",
                   k, obs_q[k].source, obs_q[k].data, obs_cyc_q[k],
                   exp_q[k].source, exp_q[k].data, acc_cyc_q[k] + 2);
        end
      end
    end
    clear_q();
  endtask

  task automatic test_backpressure_wrap();
    req_t r;
    int   acc;
    int   bound;
    clear_q();
    acc = 0;
    r = rand_req(1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, r, 1'b0);
      if (s_fired) begin acc++; r = rand_req(1'b0); end
    end
    checks++;
    if (acc != DEPTH || s_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accepts got %0d ready=%b required %0d 0", acc, s_ready, DEPTH);
    end
    for (int k = 0; k < 20 && obs_q.size() < DEPTH; k++) cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (obs_q.size() != DEPTH) begin
      errors++; $display("FAIL bp_drain beats=%0d required %0d", obs_q.size(), DEPTH);
    end
    // Ten more transactions under random d_ready to walk the pointers around the ring.
    acc = 0; bound = 0;
    while (acc < 10 && bound < 300) begin
      cycle(1'b1, r, 1'($urandom));
      checks++;
      if (s_ready !== exp_ready) begin
        errors++; $display("FAIL wrap_ready got %b required %b", s_ready, exp_ready);
      end
      if (s_fired) begin acc++; r = rand_req(1'b0); end
      bound++;
    end
    for (int k = 0; k < 40 && obs_q.size() < exp_q.size(); k++) cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (obs_q.size() != 13 || exp_q.size() != 13) begin
      errors++;
      $display("FAIL wrap_count beats=%0d expected=%0d required 13", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      resp_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_beat got src=%h size=%0d data=%h required src=%h size=%0d data=%h",
                 o.source, o.size, o.data, e.source, e.size, e.data);
      end
    end
    clear_q();
  endtask

  task automatic test_illegal();
    req_t r;
    clear_q();
    r = mk_get(17'h08000, 10'h2A5, 8'hFF, 2'd3);
    cycle(1'b1, r, 1'b1);
    checks++;
    if (s_fired !== 1'b1 || s_rom_req !== 1'b0) begin
      errors++; $display("FAIL oor_req fired=%b rom_req=%b required 1 0", s_fired, s_rom_req);
    end
    repeat (2) cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (s_dv !== 1'b1 || s_d !== {2'd3, 10'h2A5, 64'd0} || status_illegal !== 1'b0) begin
      errors++;
      $display("FAIL oor_resp dv=%b data=%h src=%h status=%b required 1 0 2a5 0",
               s_dv, s_d.data, s_d.source, status_illegal);
    end
    r = mk_get(17'h00010, 10'h0C3, 8'hFF, 2'd2);
    r.opcode = 3'd0;
    cycle(1'b1, r, 1'b1);
    checks++;
    if (s_fired !== 1'b1 || s_rom_req !== 1'b0) begin
      errors++; $display("FAIL put_req fired=%b rom_req=%b required 1 0", s_fired, s_rom_req);
    end
    cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (status_illegal !== 1'b1) begin
      errors++; $display("FAIL put_status got %b required 1", status_illegal);
    end
    cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (s_dv !== 1'b1 || s_d !== {2'd2, 10'h0C3, 64'd0}) begin
      errors++;
      $display("FAIL put_resp dv=%b data=%h src=%h required 1 0 0c3", s_dv, s_d.data, s_d.source);
    end
    cycle(1'b1, mk_get(17'h00018, 10'h001, 8'hFF, 2'd3), 1'b1);
    repeat (4) cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (status_illegal !== 1'b1 || obs_q.size() != 3 || obs_q[2] !== exp_q[2]) begin
      errors++;
      $display("FAIL sticky status=%b beats=%0d required 1 3", status_illegal, obs_q.size());
    end
    clear_q();
  endtask

  task automatic test_random();
    req_t r;
    logic have;
    clear_q();
    have = 1'b0;
    r = idle_r;
    for (int i = 0; i < 400; i++) begin
      if (!have && ($urandom % 4 != 0)) begin r = rand_req(1'b1); have = 1'b1; end
      cycle(have, r, ($urandom % 3) != 0);
      checks++;
      if (s_ready !== exp_ready || s_rom_req !== exp_rom_req) begin
        errors++;
        $display("FAIL rand_ctrl cyc=%0d ready=%b rom_req=%b required %b %b",
                 cyc, s_ready, s_rom_req, exp_ready, exp_rom_req);
      end
      if (s_fired) have = 1'b0;
    end
    for (int k = 0; k < 40 && obs_q.size() < exp_q.size(); k++) cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count beats=%0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      resp_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rand_beat got src=%h size=%0d data=%h required src=%h size=%0d data=%h",
                 o.source, o.size, o.data, e.source, e.size, e.data);
      end
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    clear_q();
    cycle(1'b1, mk_get(17'h00020, 10'h011, 8'hFF, 2'd3), 1'b0);
    cycle(1'b1, mk_get(17'h00028, 10'h012, 8'hFF, 2'd3), 1'b0);
    repeat (2) cycle(1'b0, idle_r, 1'b0);
    checks++;
    if (s_dv !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre dv=%b required 1", s_dv);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (d_valid !== 1'b0 || a_ready !== 1'b0 || d_data !== 64'd0 || d_source !== 10'd0) begin
      errors++;
      $display("FAIL rstmid_async dv=%b ready=%b data=%h src=%h required 0 0 0 0",
               d_valid, a_ready, d_data, d_source);
    end
    @(negedge clock);
    reset = 1'b1;
    outstanding = 0; clear_q();
    cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (s_ready !== 1'b1 || status_illegal !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready ready=%b status=%b required 1 0", s_ready, status_illegal);
    end
    repeat (6) cycle(1'b0, idle_r, 1'b1);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL rstmid_stale beats=%0d required 0", obs_q.size());
    end
    clear_q();
  endtask

  initial begin
    idle_r = '0;
    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = {$urandom, $urandom};
    rom_mem[2] = 64'h0123456789ABCDEF;
    test_reset();
    test_single_get(8'hFF, 64'h0123456789ABCDEF);
    test_single_get(8'h0F, 64'h0000000089ABCDEF);
    test_back_to_back();
    test_backpressure_wrap();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_rom_slave.md
Name: tl_rom_slave

Overview:
- Read-only TileLink-UL slave that sits directly downstream of the fragmenter coupler.
- Consumes single-beat A requests: size ≤ 8 bytes, 10-bit source, 17-bit address, 8-bit mask, no A data.
- Reads a synchronous ROM macro with 1-cycle latency and returns D responses through a small response queue.
- Provides full-rate pipelined throughput with backpressure on both channels.

Parameters:
- SRC_W, 10, A/D source width
- ADDR_W, 17, A address width (byte address)
- ROM_WORDS, 4096, number of 64-bit ROM words implemented
- RESP_DEPTH, 3, response queue entries; in-flight requests count against it

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- auto_in_a_ready  out  1  A accept
- auto_in_a_valid  in  1  A request valid
- auto_in_a_bits_opcode  in  3  4=Get; all other values are illegal
- auto_in_a_bits_param  in  3  ignored
- auto_in_a_bits_size  in  2  log2 bytes
- auto_in_a_bits_source  in  SRC_W  request id
- auto_in_a_bits_address  in  ADDR_W  byte address
- auto_in_a_bits_mask  in  8  byte lanes
- auto_in_a_bits_corrupt  in  1  request corrupt
- auto_in_d_ready  in  1  D accept
- auto_in_d_valid  out  1  D response valid
- auto_in_d_bits_size  out  2  echoed size
- auto_in_d_bits_source  out  SRC_W  echoed source
- auto_in_d_bits_data  out  64  lane-masked read data
- rom_req  out  1  ROM read enable
- rom_addr  out  12  word index = address[14:3]
- rom_rdata  in  64  ROM data, valid the cycle after rom_req
- status_illegal  out  1  sticky flag for illegal opcode or corrupt request

Behaviour:
- Reset: all state cleared asynchronously while reset=0.
  - auto_in_d_valid=0, auto_in_a_ready=0, rom_req=0, status_illegal=0.
  - auto_in_d_bits_* read as 0.
  - auto_in_a_ready rises in the first cycle after reset deassertion.
- Occupancy = p_valid (0/1) + queue count.
  - auto_in_a_ready = occupancy < RESP_DEPTH.
  - auto_in_a_ready is driven only from registers: no combinational path from auto_in_a_valid or auto_in_d_ready.
- Accept (a_fire = a_valid & a_ready) at cycle t:
  - Capture the pipeline register p: size, source, mask, zero flag.
  - zero = address[16:3] ≥ ROM_WORDS, or opcode≠4, or corrupt=1.
  - rom_req = a_fire & !zero (combinational, same cycle); rom_addr = address[14:3].
- Cycle t+1:
  - Enqueue {p_size, p_source, data} into the queue.
  - data = zero ? 0 : rom_rdata with byte lane i forced to 0 when p_mask[i]=0.
  - The address low bits [2:0] are not used; the mask selects lanes.
- auto_in_d_valid = count≠0.
  - D outputs come from the queue head.
  - Dequeue on d_valid & d_ready.
  - Enqueue and dequeue in the same cycle are legal; count is unchanged.
- Latency: accept at t → d_valid at t+2 when the queue is empty. Responses are strictly in order.
- Throughput: with RESP_DEPTH=3 and d_ready held 1, one request is accepted per cycle indefinitely.
- Full: when occupancy = RESP_DEPTH, a_ready=0.
  - The pending request must be held by the master; the slave requires no stability check.
  - Queue overflow is impossible by construction.
- Queue: circular buffer with wrap-around read/write pointers modulo RESP_DEPTH; count ranges 0..RESP_DEPTH.
- status_illegal: set on a_fire with opcode≠4 or corrupt=1; cleared only by reset. The request is still answered, with data 0.
- Reset mid-operation: in-flight and queued responses are discarded with no D beat emitted. Outputs return to reset values immediately.
- a_param and the upper address bits above the ROM index are ignored, apart from the range check.

Test Plan:
- Single Get: addr 0x00010, size 3, mask 0xFF, src 0x155, ROM word 2 = 0x0123456789ABCDEF → rom_req with rom_addr=2 at t; d_valid at t+2 with data 0x0123456789ABCDEF, src 0x155, size 3.
- Partial lanes: Get, mask 0x0F, same word → data 0x0000000089ABCDEF.
- Back-to-back, d_ready=1: 8 Gets, addrs 0x0, 0x8, … 0x38, srcs 0–7 → a_ready stays 1; 8 in-order D beats on consecutive cycles t+2..t+9.
- Backpressure and wrap:
  - d_ready=0, issue Gets → a_ready drops after 3 accepts.
  - Release d_ready → 3 beats drain in order; after 10 more transactions, pointers wrap with no loss or duplication.
- Out-of-range/illegal:
  - Get at 0x08000 (word 4096) → no rom_req, data 0, status_illegal stays 0.
  - PutFull (opcode 0) → data 0 response, status_illegal=1 and sticky.
- Reset mid-operation: queue holding 2 entries, assert reset=0 → d_valid=0 immediately; after release, no stale beat appears and a_ready=1 in the next cycle.
